// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared bus widths, response owner encoding and arbiter defaults
package sram_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        OWN_IDLE   = 2'd0,
        OWN_RESP_I = 2'd1,
        OWN_RESP_D = 2'd2
    } owner_e;

    // Width needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// rtl/sram_arb_prio.sv - data-first grant with starvation escape for the fetch port
module sram_arb_prio
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic data_req,
    output logic inst_grant,
    output logic data_grant
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == LIMIT);

    // Grants are forced low while reset is held so the SRAM sees no command.
    always_comb begin
        inst_grant = 1'b0;
        data_grant = 1'b0;
        if (resetn) begin
            if (data_req && !(inst_req && starved)) begin
                data_grant = 1'b1;
            end else if (inst_req) begin
                inst_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (inst_grant || !inst_req) begin
            starve_cnt <= '0;
        end else if (data_grant && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port SRAM between fetch and load/store ports
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [STRB_W-1:0] data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              sram_en,
    output logic [STRB_W-1:0] sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic   inst_grant;
    logic   data_grant;
    owner_e state_q;
    owner_e state_d;

    sram_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (inst_req),
        .data_req   (data_req),
        .inst_grant (inst_grant),
        .data_grant (data_grant)
    );

    assign inst_addr_ok = inst_grant;
    assign data_addr_ok = data_grant;
    assign sram_en      = inst_grant | data_grant;

    always_comb begin
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (data_grant) begin
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_grant) begin
            sram_addr  = inst_addr;
        end
    end

    // The owner of next cycle's read data is whoever is granted now, regardless of history.
    always_comb begin
        state_d = OWN_IDLE;
        if (inst_grant) begin
            state_d = OWN_RESP_I;
        end else if (data_grant) begin
            state_d = OWN_RESP_D;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= OWN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        case (state_q)
            OWN_RESP_I: begin
                inst_data_ok = 1'b1;
                inst_rdata   = sram_rdata;
            end
            OWN_RESP_D: begin
                data_data_ok = 1'b1;
                data_rdata   = sram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scenario tests and response scoreboard for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_inst;
        logic        is_write;
        logic [31:0] rdata;
    } resp_t;

    resp_t sb_q[$];
    logic [31:0] mem [int unsigned];

    sram_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        if (mem.exists(addr[31:2])) return mem[addr[31:2]];
        return 32'h0;
    endfunction

    // Behavioural SRAM: read data appears the cycle after the command.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_rdata <= mem_read(sram_addr);
            end else begin
                logic [31:0] w;
                w = mem_read(sram_addr);
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
                mem[sram_addr[31:2]] = w;
                sram_rdata <= 32'h0;
            end
        end
    end

    // Scoreboard: each grant expects exactly one response on the following cycle.
    always @(negedge clk) begin
        if (!resetn) begin
            sb_q.delete();
        end else begin
            checks++;
            if (inst_data_ok && data_data_ok) begin
                errors++;
                $display("FAIL both_data_ok: inst=%0b data=%0b required not both", inst_data_ok, data_data_ok);
            end
            if (sb_q.size() != 0) begin
                resp_t e;
                e = sb_q.pop_front();
                checks++;
                if (inst_data_ok !== e.is_inst || data_data_ok !== !e.is_inst) begin
                    errors++;
                    $display("FAIL sb_resp_ok: inst_ok=%0b data_ok=%0b required inst_ok=%0b data_ok=%0b",
                             inst_data_ok, data_data_ok, e.is_inst, !e.is_inst);
                end else if (!e.is_write) begin
                    logic [31:0] got;
                    got = e.is_inst ? inst_rdata : data_rdata;
                    checks++;
                    if (got !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_rdata: got %h required %h", got, e.rdata);
                    end
                end
            end else if (inst_data_ok || data_data_ok) begin
                errors++;
                $display("FAIL sb_spurious: inst_ok=%0b data_ok=%0b required 0 0", inst_data_ok, data_data_ok);
            end
            if (inst_addr_ok) begin
                checks++;
                if (sram_addr !== inst_addr || sram_we !== 4'h0 || sram_wdata !== 32'h0 || sram_en !== 1'b1) begin
                    errors++;
                    $display("FAIL inst_cmd: en=%0b addr=%h we=%h wd=%h required 1 %h 0 0",
                             sram_en, sram_addr, sram_we, sram_wdata, inst_addr);
                end
                sb_q.push_back('{is_inst: 1'b1, is_write: 1'b0, rdata: mem_read(inst_addr)});
            end else if (data_addr_ok) begin
                checks++;
                if (sram_addr !== data_addr || sram_we !== data_we || sram_wdata !== data_wdata || sram_en !== 1'b1) begin
                    errors++;
                    $display("FAIL data_cmd: en=%0b addr=%h we=%h wd=%h required 1 %h %h %h",
                             sram_en, sram_addr, sram_we, sram_wdata, data_addr, data_we, data_wdata);
                end
                sb_q.push_back('{is_inst: 1'b0, is_write: (data_we != 4'h0), rdata: mem_read(data_addr)});
            end else begin
                checks++;
                if (sram_en !== 1'b0 || sram_we !== 4'h0 || sram_addr !== 32'h0 || sram_wdata !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_cmd: en=%0b we=%h addr=%h wd=%h required all 0",
                             sram_en, sram_we, sram_addr, sram_wdata);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        inst_req = 1'b0;
        data_req = 1'b0;
        data_we  = 4'h0;
        next_cycle();
        next_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we} !== 9'h0) begin
            errors++;
            $display("FAIL %s: addr_ok=%0b%0b data_ok=%0b%0b en=%0b we=%h required all 0", tag,
                     inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en, sram_we);
        end
    endtask

    task automatic check_grant(input string tag, input logic exp_i, input logic exp_d);
        checks++;
        if (inst_addr_ok !== exp_i || data_addr_ok !== exp_d) begin
            errors++;
            $display("FAIL %s: inst_addr_ok=%0b data_addr_ok=%0b required %0b %0b",
                     tag, inst_addr_ok, data_addr_ok, exp_i, exp_d);
        end
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        data_we  = 4'hF;
        inst_addr  = 32'h1C00_0000;
        data_addr  = 32'h0000_0300;
        data_wdata = 32'hA5A5_A5A5;
        repeat (3) next_cycle();
        check_reset_outputs("reset_outputs");
        data_we = 4'h0;
        next_cycle();
        resetn = 1'b1;
        #1;
        check_grant("first_grant_after_reset", 1'b0, 1'b1);
        next_cycle();
        go_idle();
    endtask

    task automatic test_inst_read();
        mem[32'h1C00_0000 >> 2] = 32'hDEAD_BEEF;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        check_grant("inst_read_grant", 1'b1, 1'b0);
        next_cycle();
        inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL inst_read_data: ok=%0b rdata=%h required 1 deadbeef", inst_data_ok, inst_rdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL inst_ok_one_cycle: ok=%0b required 0", inst_data_ok);
        end
        go_idle();
    endtask

    task automatic test_same_cycle();
        mem[32'h100 >> 2] = 32'h0BAD_F00D;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        data_req  = 1'b1;
        data_we   = 4'h0;
        data_addr = 32'h0000_0100;
        @(negedge clk);
        check_grant("same_cycle_t", 1'b0, 1'b1);
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        check_grant("same_cycle_t1", 1'b1, 1'b0);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL same_cycle_load: ok=%0b rdata=%h required 1 0badf00d", data_data_ok, data_rdata);
        end
        next_cycle();
        inst_req = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_t2: inst_ok=%0b data_ok=%0b required 1 0", inst_data_ok, data_data_ok);
        end
        go_idle();
    endtask

    // With inst waiting, four data grants then one inst grant, repeating.
    task automatic run_starve_pattern(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            data_addr = 32'h0000_0400 + 32'(i * 4);
            #1;
            @(negedge clk);
            if (i % 5 == 4) check_grant(tag, 1'b1, 1'b0);
            else            check_grant(tag, 1'b0, 1'b1);
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 10; i++) mem[(32'h400 >> 2) + i] = 32'hC0DE_0000 + 32'(i);
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        data_req  = 1'b1;
        data_we   = 4'h0;
        run_starve_pattern("starve", 10);
        go_idle();
    endtask

    task automatic test_back_to_back();
        data_req   = 1'b1;
        data_we    = 4'hF;
        data_addr  = 32'h0000_0200;
        data_wdata = 32'h1234_5678;
        @(negedge clk);
        check_grant("store_grant", 1'b0, 1'b1);
        checks++;
        if (sram_we !== 4'hF) begin
            errors++;
            $display("FAIL store_we: sram_we=%h required f", sram_we);
        end
        next_cycle();
        data_we    = 4'h0;
        data_wdata = 32'h0;
        @(negedge clk);
        check_grant("load_grant", 1'b0, 1'b1);
        checks++;
        if (data_data_ok !== 1'b1) begin
            errors++;
            $display("FAIL store_ack: data_ok=%0b required 1", data_data_ok);
        end
        next_cycle();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL load_after_store: ok=%0b rdata=%h required 1 12345678", data_data_ok, data_rdata);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        check_grant("pre_reset_inst_grant", 1'b1, 1'b0);
        next_cycle();
        resetn   = 1'b0;
        data_req = 1'b1;
        data_we  = 4'hF;
        #1;
        check_reset_outputs("reset_drops_inst_resp");
        next_cycle();
        check_reset_outputs("reset_held");
        inst_req = 1'b0;
        data_req = 1'b0;
        data_we  = 4'h0;
        resetn   = 1'b1;
        repeat (2) next_cycle();
        checks++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL no_resp_after_reset: inst_ok=%0b data_ok=%0b required 0 0", inst_data_ok, data_data_ok);
        end
        // Build up the starve count, then reset with a data response in flight.
        inst_req = 1'b1;
        data_req = 1'b1;
        run_starve_pattern("charge", 3);
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        run_starve_pattern("counter_cleared", 10);
        go_idle();
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_we    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        test_reset();
        test_inst_read();
        test_same_cycle();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
